line_buffer_ctrl: RTL and testbench

//  Sequences a ring of NUM_LB = KERNEL_SIZE+1 line buffers for the sliding-window filter stages.

---
 rtl/linebuf_pkg.sv | 21 ++
 rtl/window_mux.sv | 31 +++
 rtl/line_buffer_ctrl.sv | 131 +++++++++++++
 tb/tb_line_buffer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the line-buffer ring controller.
//   num_lb()    : number of line buffers in the ring for a given kernel height
//   lb_state_t  : controller FSM state
//   ring_idx_t  : index into the ring. It is sized for up to 16 buffers so that one
//                 type serves every kernel size. Wrap is done by compare, not by overflow.
package linebuf_pkg;

    localparam int RING_IDX_W = 4;

    function automatic int num_lb(input int k);
        return k + 1;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } lb_state_t;

    typedef logic [RING_IDX_W-1:0] ring_idx_t;

endpackage

// File: rtl/window_mux.sv
// Rotates the NUM_LB line-buffer row slices so that window row 0 is the buffer at
// rd_sel, which holds the oldest line. The unused (write) buffer is dropped.
//   lb_data  : NUM_LB slices of KERNEL_SIZE*NBIT, buffer b at slice b
//   rd_sel   : ring index of the oldest active line
//   win_data : KERNEL_SIZE rows, row r = buffer (rd_sel+r) % NUM_LB
module window_mux
    import linebuf_pkg::*;
#(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_LB      = 4
) (
    input  logic [NUM_LB*KERNEL_SIZE*NBIT-1:0]      lb_data,
    input  ring_idx_t                               rd_sel,
    output logic [KERNEL_SIZE*KERNEL_SIZE*NBIT-1:0] win_data
);

    localparam int ROW_W = KERNEL_SIZE * NBIT;

    always_comb begin
        win_data = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int s = 0; s < NUM_LB; s++) begin
                if (rd_sel == ring_idx_t'(s)) begin
                    win_data[r*ROW_W +: ROW_W] = lb_data[((s + r) % NUM_LB)*ROW_W +: ROW_W];
                end
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequences a ring of KERNEL_SIZE+1 line buffers for a sliding-window filter.
// The incoming pixel stream is steered into one buffer per line. KERNEL_SIZE buffers
// are read in lockstep and assembled into a KxK window. One buffer is freed per
// completed output line.
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_pix_data/valid, o_pix_ready upstream pixel handshake
//   o_lb_data, o_lb_wr_valid     pixel broadcast and one-hot write enable to buffers
//   o_lb_rd_valid                read-pointer advance for the active buffers
//   i_lb_data                    concatenated buffer outputs
//   o_win_data/valid, i_win_ready window handshake to the kernel datapath
//   o_win_col                    column of the window's left pixel
//   o_line_done                  one-cycle pulse after an output line completes
//
// state   | meaning
// ST_IDLE | fewer than KERNEL_SIZE full lines buffered, or gap between output lines
// ST_RD   | window valid; each accepted window advances the read column
module line_buffer_ctrl
    import linebuf_pkg::*;
#(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_WIDTH = 512,
    localparam int NUM_LB     = num_lb(KERNEL_SIZE),
    localparam int CW         = $clog2(IMAGE_WIDTH)
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NBIT-1:0]                         i_pix_data,
    input  logic                                    i_pix_valid,
    output logic                                    o_pix_ready,
    output logic [NBIT-1:0]                         o_lb_data,
    output logic [NUM_LB-1:0]                       o_lb_wr_valid,
    output logic [NUM_LB-1:0]                       o_lb_rd_valid,
    input  logic [NUM_LB*KERNEL_SIZE*NBIT-1:0]      i_lb_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*NBIT-1:0] o_win_data,
    output logic                                    o_win_valid,
    input  logic                                    i_win_ready,
    output logic [CW-1:0]                           o_win_col,
    output logic                                    o_line_done
);

    localparam int FW = $clog2(NUM_LB*IMAGE_WIDTH + 1);

    lb_state_t         state, state_nxt;
    ring_idx_t         wr_sel, rd_sel;
    logic [CW-1:0]     wr_cnt, rd_cnt;
    logic [FW-1:0]     fill;
    logic              wr, rd, free, line_done_q;
    logic [NUM_LB-1:0] rd_mask;

    function automatic ring_idx_t ring_next(input ring_idx_t s);
        return (s == ring_idx_t'(NUM_LB-1)) ? '0 : s + 1'b1;
    endfunction

    // Gating with i_rst keeps the write strobe quiet while the ring is held in reset,
    // even though o_pix_ready reads 1 there.
    assign o_pix_ready = (fill < FW'(NUM_LB*IMAGE_WIDTH));
    assign wr          = i_pix_valid & o_pix_ready & i_rst;
    assign o_lb_data   = i_pix_data;
    assign o_win_col   = rd_cnt;
    assign o_line_done = line_done_q;

    always_comb begin
        state_nxt   = state;
        o_win_valid = 1'b0;
        rd          = 1'b0;
        free        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fill >= FW'(KERNEL_SIZE*IMAGE_WIDTH)) state_nxt = ST_RD;
            end
            ST_RD: begin
                o_win_valid = 1'b1;
                rd          = i_win_ready;
                if (rd && (rd_cnt == CW'(IMAGE_WIDTH-1))) begin
                    free      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mask = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int s = 0; s < NUM_LB; s++) begin
                if (rd_sel == ring_idx_t'(s)) rd_mask[(s + r) % NUM_LB] = 1'b1;
            end
        end
    end

    assign o_lb_wr_valid = wr ? (NUM_LB'(1) << wr_sel) : '0;
    assign o_lb_rd_valid = rd ? rd_mask : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            wr_sel      <= '0;
            rd_sel      <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            fill        <= '0;
            line_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            line_done_q <= free;
            fill        <= fill + FW'(wr) - (free ? FW'(IMAGE_WIDTH) : '0);
            // IMAGE_WIDTH is a power of two, so the column counters wrap on their own.
            if (wr) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == CW'(IMAGE_WIDTH-1)) wr_sel <= ring_next(wr_sel);
            end
            if (rd) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (free) rd_sel <= ring_next(rd_sel);
            end
        end
    end

    window_mux #(
        .NBIT        (NBIT),
        .KERNEL_SIZE (KERNEL_SIZE),
        .NUM_LB      (NUM_LB)
    ) u_window_mux (
        .lb_data  (i_lb_data),
        .rd_sel   (rd_sel),
        .win_data (o_win_data)
    );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with behavioural line-buffer models.
module tb_line_buffer_ctrl;

    localparam int NBIT = 8;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int NLB  = 4;
    localparam int WINW = K*K*NBIT;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [NBIT-1:0]   i_pix_data = '0;
    logic              i_pix_valid = 1'b0;
    logic              o_pix_ready;
    logic [NBIT-1:0]   o_lb_data;
    logic [NLB-1:0]    o_lb_wr_valid;
    logic [NLB-1:0]    o_lb_rd_valid;
    logic [NLB*K*NBIT-1:0] i_lb_data;
    logic [WINW-1:0]   o_win_data;
    logic              o_win_valid;
    logic              i_win_ready = 1'b0;
    logic [2:0]        o_win_col;
    logic              o_line_done;

    int total = 0;
    int bad   = 0;
    bit ovf_seen = 1'b0;

    always #5 i_clk = ~i_clk;

    line_buffer_ctrl #(.NBIT(NBIT), .KERNEL_SIZE(K), .IMAGE_WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pix_data    (i_pix_data),
        .i_pix_valid   (i_pix_valid),
        .o_pix_ready   (o_pix_ready),
        .o_lb_data     (o_lb_data),
        .o_lb_wr_valid (o_lb_wr_valid),
        .o_lb_rd_valid (o_lb_rd_valid),
        .i_lb_data     (i_lb_data),
        .o_win_data    (o_win_data),
        .o_win_valid   (o_win_valid),
        .i_win_ready   (i_win_ready),
        .o_win_col     (o_win_col),
        .o_line_done   (o_line_done)
    );

    // Behavioural line buffers: each presents K consecutive pixels from its read pointer.
    logic [NBIT-1:0] mem [NLB][W];
    int wptr [NLB];
    int rptr [NLB];

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int b = 0; b < NLB; b++) begin
                wptr[b] <= 0;
                rptr[b] <= 0;
            end
        end else begin
            for (int b = 0; b < NLB; b++) begin
                if (o_lb_wr_valid[b]) begin
                    mem[b][wptr[b]] <= o_lb_data;
                    wptr[b] <= (wptr[b] + 1) % W;
                end
                if (o_lb_rd_valid[b]) rptr[b] <= (rptr[b] + 1) % W;
            end
        end
    end

    always_comb begin
        i_lb_data = '0;
        for (int b = 0; b < NLB; b++)
            for (int j = 0; j < K; j++)
                i_lb_data[(b*K + j)*NBIT +: NBIT] = mem[b][(rptr[b] + j) % W];
    end

    // Fill must stay within 0..NLB*W; an underflow wraps to a large value.
    always @(negedge i_clk) begin
        if (i_rst && (dut.fill > 6'd32)) ovf_seen = 1'b1;
    end

    // Expected window for output line line_idx at column col, pixels numbered from off.
    function automatic logic [WINW-1:0] exp_win(input int line_idx, input int col, input int off);
        logic [WINW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int j = 0; j < K; j++)
                v[(r*K + j)*NBIT +: NBIT] = NBIT'(off + (line_idx + r)*W + (col + j) % W);
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_pix_valid = 1'b0;
        i_win_ready = 1'b0;
        i_rst = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        #1 i_rst = 1'b0;
        i_pix_valid = 1'b1;
        i_pix_data  = 8'd99;
        #1;
        total++; if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b exp=1", o_pix_ready); end
        total++; if (o_win_valid !== 1'b0) begin bad++; $display("FAIL rst_win_valid: got=%b exp=0", o_win_valid); end
        total++; if (o_line_done !== 1'b0) begin bad++; $display("FAIL rst_line_done: got=%b exp=0", o_line_done); end
        total++; if (o_lb_wr_valid !== 4'b0000) begin bad++; $display("FAIL rst_wr_valid: got=%b exp=0000", o_lb_wr_valid); end
        total++; if (o_lb_rd_valid !== 4'b0000) begin bad++; $display("FAIL rst_rd_valid: got=%b exp=0000", o_lb_rd_valid); end
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            i_pix_data = 8'(100 + i);
            #1;
            if (i == 0) begin
                total++; if (o_lb_wr_valid !== 4'b0001) begin bad++; $display("FAIL first_wr_lb0: got=%b exp=0001", o_lb_wr_valid); end
            end
            tick();
        end
        #1;
        total++; if (dut.fill !== 6'd13) begin bad++; $display("FAIL fill13: got=%0d exp=13", dut.fill); end
        total++; if (o_lb_wr_valid !== 4'b0010) begin bad++; $display("FAIL wr_lb1: got=%b exp=0010", o_lb_wr_valid); end
        i_rst = 1'b0;
        #1;
        total++; if (dut.fill !== 6'd0) begin bad++; $display("FAIL midrst_fill: got=%0d exp=0", dut.fill); end
        total++; if (dut.wr_sel !== '0) begin bad++; $display("FAIL midrst_wr_sel: got=%0d exp=0", dut.wr_sel); end
        total++; if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got=%b exp=1", o_pix_ready); end
        total++; if (o_lb_wr_valid !== 4'b0000) begin bad++; $display("FAIL midrst_wr_valid: got=%b exp=0000", o_lb_wr_valid); end
        tick();
        i_rst = 1'b1;
        i_pix_data = 8'd200;
        #1;
        total++; if (o_lb_wr_valid !== 4'b0001) begin bad++; $display("FAIL post_rst_wr_lb0: got=%b exp=0001", o_lb_wr_valid); end
        tick();
        i_pix_valid = 1'b0;
        total++; if (mem[0][0] !== 8'd200) begin bad++; $display("FAIL post_rst_mem: got=%0d exp=200", mem[0][0]); end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        i_win_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            i_pix_valid = 1'b1;
            i_pix_data  = 8'(i);
            tick();
        end
        i_pix_valid = 1'b0;
        #1;
        total++; if (o_win_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got=%b exp=0", o_win_valid); end
        n = 0;
        while (!o_win_valid && n < 4) begin
            tick();
            n++;
        end
        total++; if (n !== 1) begin bad++; $display("FAIL valid_rise: got=%0d cycles exp=1", n); end
        for (int k = 0; k < W; k++) begin
            #1;
            total++; if (o_win_col !== 3'(k)) begin bad++; $display("FAIL stream_col: got=%0d exp=%0d", o_win_col, k); end
            total++; if (o_win_data !== exp_win(0, k, 0)) begin bad++; $display("FAIL stream_win col%0d: got=%h exp=%h", k, o_win_data, exp_win(0, k, 0)); end
            total++; if (o_lb_rd_valid !== 4'b0111) begin bad++; $display("FAIL stream_rd_mask: got=%b exp=0111", o_lb_rd_valid); end
            total++; if (o_line_done !== 1'b0) begin bad++; $display("FAIL stream_early_done: got=%b exp=0", o_line_done); end
            tick();
        end
        total++; if (o_line_done !== 1'b1) begin bad++; $display("FAIL stream_done: got=%b exp=1", o_line_done); end
        total++; if (o_win_valid !== 1'b0) begin bad++; $display("FAIL stream_idle_gap: got=%b exp=0", o_win_valid); end
        total++; if (dut.fill !== 6'd16) begin bad++; $display("FAIL stream_fill: got=%0d exp=16", dut.fill); end
        total++; if (dut.rd_sel !== 4'd1) begin bad++; $display("FAIL stream_rd_sel: got=%0d exp=1", dut.rd_sel); end
        tick();
        total++; if (o_line_done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got=%b exp=0", o_line_done); end
        i_win_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            i_pix_valid = 1'b1;
            i_pix_data  = 8'(i);
            tick();
        end
        #1;
        total++; if (o_pix_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got=%b exp=0", o_pix_ready); end
        total++; if (dut.fill !== 6'd32) begin bad++; $display("FAIL full_fill: got=%0d exp=32", dut.fill); end
        total++; if (o_win_valid !== 1'b1) begin bad++; $display("FAIL full_win_valid: got=%b exp=1", o_win_valid); end
        i_pix_data = 8'd32;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (o_lb_wr_valid !== 4'b0000) begin bad++; $display("FAIL held_wr: got=%b exp=0000", o_lb_wr_valid); end
            tick();
        end
        total++; if (mem[0][0] !== 8'd0) begin bad++; $display("FAIL held_mem: got=%0d exp=0", mem[0][0]); end
        total++; if (dut.fill !== 6'd32) begin bad++; $display("FAIL held_fill: got=%0d exp=32", dut.fill); end
    endtask

    task automatic test_release();
        i_win_ready = 1'b1;
        for (int k = 0; k < W; k++) tick();
        i_win_ready = 1'b0;
        #1;
        total++; if (dut.fill !== 6'd24) begin bad++; $display("FAIL rel_fill: got=%0d exp=24", dut.fill); end
        total++; if (o_pix_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got=%b exp=1", o_pix_ready); end
        total++; if (o_line_done !== 1'b1) begin bad++; $display("FAIL rel_done: got=%b exp=1", o_line_done); end
        total++; if (o_lb_wr_valid !== 4'b0001) begin bad++; $display("FAIL rel_wr_lb0: got=%b exp=0001", o_lb_wr_valid); end
        total++; if (dut.rd_sel !== 4'd1) begin bad++; $display("FAIL rel_rd_sel: got=%0d exp=1", dut.rd_sel); end
        tick();
        i_pix_valid = 1'b0;
        total++; if (mem[0][0] !== 8'd32) begin bad++; $display("FAIL rel_mem: got=%0d exp=32", mem[0][0]); end
        total++; if (dut.fill !== 6'd25) begin bad++; $display("FAIL rel_fill25: got=%0d exp=25", dut.fill); end
    endtask

    task automatic test_wr_and_free();
        i_win_ready = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (k == W-1) begin
                i_pix_valid = 1'b1;
                i_pix_data  = 8'd33;
            end
            #1;
            total++; if (o_win_data !== exp_win(1, k, 0)) begin bad++; $display("FAIL wf_win col%0d: got=%h exp=%h", k, o_win_data, exp_win(1, k, 0)); end
            total++; if (o_lb_rd_valid !== 4'b1110) begin bad++; $display("FAIL wf_rd_mask: got=%b exp=1110", o_lb_rd_valid); end
            tick();
        end
        i_pix_valid = 1'b0;
        i_win_ready = 1'b0;
        total++; if (dut.fill !== 6'd18) begin bad++; $display("FAIL wf_fill: got=%0d exp=18", dut.fill); end
        total++; if (o_line_done !== 1'b1) begin bad++; $display("FAIL wf_done: got=%b exp=1", o_line_done); end
        total++; if (mem[0][1] !== 8'd33) begin bad++; $display("FAIL wf_mem: got=%0d exp=33", mem[0][1]); end
    endtask

    task automatic test_random();
        int written, pulses, line_out, exp_col, cyc, viol, d;
        do_reset();
        written = 0; pulses = 0; line_out = 0; exp_col = 0; cyc = 0; viol = 0;
        while (pulses < 4 && cyc < 3000) begin
            i_pix_valid = (written < 48) && ($urandom_range(0, 1) == 1);
            i_pix_data  = 8'(50 + written);
            i_win_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (o_win_valid && i_win_ready) begin
                total++;
                if ((o_win_data !== exp_win(line_out, exp_col, 50)) || (o_win_col !== 3'(exp_col))) begin
                    bad++;
                    $display("FAIL rand_win line%0d col%0d: got=%h/%0d exp=%h", line_out, exp_col, o_win_data, o_win_col, exp_win(line_out, exp_col, 50));
                end
                exp_col = (exp_col + 1) % W;
            end
            if ((o_lb_wr_valid & o_lb_rd_valid) != 4'b0000) viol++;
            if (o_win_valid && o_pix_ready) begin
                d = (int'(dut.wr_sel) - int'(dut.rd_sel) + NLB) % NLB;
                if (d != K) viol++;
            end
            if (o_pix_ready && i_pix_valid) written++;
            if (o_line_done) begin
                pulses++;
                line_out++;
            end
            tick();
            cyc++;
        end
        i_pix_valid = 1'b0;
        i_win_ready = 1'b0;
        total++; if (pulses !== 4) begin bad++; $display("FAIL rand_pulses: got=%0d exp=4 (cycles=%0d)", pulses, cyc); end
        total++; if (written !== 48) begin bad++; $display("FAIL rand_written: got=%0d exp=48", written); end
        total++; if (viol !== 0) begin bad++; $display("FAIL rand_wr_in_rd_set: got=%0d exp=0", viol); end
        total++; if (dut.fill !== 6'd16) begin bad++; $display("FAIL rand_fill: got=%0d exp=16", dut.fill); end
        total++; if (ovf_seen !== 1'b0) begin bad++; $display("FAIL fill_range: got=%b exp=0", ovf_seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_release();
        test_wr_and_free();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
